// File: rtl/r2sdf_pkg.sv
// Shared definitions for the R2SDF FFT pipeline: frame sizing, complex sample
// type and the index bit-reversal helper.
package r2sdf_pkg;

  localparam int N_DEF = 3;
  localparam int W_DEF = 16;
  localparam int NPTS  = 1 << N_DEF;

  typedef struct packed {
    logic signed [W_DEF-1:0] re;
    logic signed [W_DEF-1:0] im;
  } cplx_t;

  // Reverses the low n bits of value; bits at and above n come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        r = {r[30:0], value[i]};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/r2sdf_bitrev_reorder_if.sv
// Streaming bundle of the reorder buffer: bit-reversed input side and
// natural-order output side, each with a valid/ready handshake.
interface r2sdf_bitrev_reorder_if
  import r2sdf_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_re;
  logic [W-1:0] in_im;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic [N-1:0] out_idx;
  logic         out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

endinterface

// File: rtl/r2sdf_pingpong_ram.sv
// Two-bank frame store: synchronous write into one bank, asynchronous read
// from the other, each bank addressed independently.
module r2sdf_pingpong_ram
  import r2sdf_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = 2 * W_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [N-1:0]  waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rbank,
  input  logic [N-1:0]  raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << N;

  logic [DW-1:0] mem_r [2][DEPTH];

  // sample write into the filling bank
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wbank][waddr] <= wdata;
    end
  end

  assign rdata = mem_r[rbank][raddr];

endmodule

// File: rtl/r2sdf_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural index order using a
// ping-pong frame buffer; one bank fills while the other drains.
module r2sdf_bitrev_reorder
  import r2sdf_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  r2sdf_bitrev_reorder_if.slave   bus
);

  localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

  logic [N-1:0]   wcnt_r;
  logic [N-1:0]   rcnt_r;
  logic           wbank_r;
  logic           rbank_r;
  logic [1:0]     full_r;
  logic [1:0]     full_s;
  logic           wr_fire_s;
  logic           wr_wrap_s;
  logic           ld_s;
  logic           rd_wrap_s;
  logic [N-1:0]   waddr_s;
  logic [2*W-1:0] rdata_s;

  logic           out_valid_r;
  logic           out_last_r;
  logic [N-1:0]   out_idx_r;
  logic [W-1:0]   out_re_r;
  logic [W-1:0]   out_im_r;

  // Ready depends only on registered flags, so out_ready never reaches in_ready.
  assign bus.in_ready  = ~full_r[wbank_r];
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_re    = out_re_r;
  assign bus.out_im    = out_im_r;

  // handshake decode, write address and next bank-full flags
  always_comb begin
    wr_fire_s = bus.in_valid & ~full_r[wbank_r];
    wr_wrap_s = wr_fire_s & (wcnt_r == CNT_MAX);
    ld_s      = (bus.out_ready | ~out_valid_r) & full_r[rbank_r];
    rd_wrap_s = ld_s & (rcnt_r == CNT_MAX);
    waddr_s   = N'(bitrev(32'(wcnt_r), N));
    full_s    = full_r;
    if (wr_wrap_s) begin
      full_s[wbank_r] = 1'b1;
    end else begin
      full_s[wbank_r] = full_r[wbank_r];
    end
    // writer and reader always address different banks when both fire
    if (rd_wrap_s) begin
      full_s[rbank_r] = 1'b0;
    end else begin
      full_s[rbank_r] = full_s[rbank_r];
    end
  end

  r2sdf_pingpong_ram #(
    .N  (N),
    .DW (2 * W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire_s),
    .wbank (wbank_r),
    .waddr (waddr_s),
    .wdata ({bus.in_re, bus.in_im}),
    .rbank (rbank_r),
    .raddr (rcnt_r),
    .rdata (rdata_s)
  );

  // write counter and filling-bank pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_r  <= {N{1'b0}};
      wbank_r <= 1'b0;
    end else if (wr_fire_s) begin
      wcnt_r <= wcnt_r + N'(1);
      if (wr_wrap_s) begin
        wbank_r <= ~wbank_r;
      end
    end
  end

  // read counter and draining-bank pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_r  <= {N{1'b0}};
      rbank_r <= 1'b0;
    end else if (ld_s) begin
      rcnt_r <= rcnt_r + N'(1);
      if (rd_wrap_s) begin
        rbank_r <= ~rbank_r;
      end
    end
  end

  // complete-frame flags per bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 2'b00;
    end else begin
      full_r <= full_s;
    end
  end

  // output register: load from the draining bank, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_idx_r   <= {N{1'b0}};
      out_re_r    <= {W{1'b0}};
      out_im_r    <= {W{1'b0}};
    end else if (ld_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= (rcnt_r == CNT_MAX);
      out_idx_r   <= rcnt_r;
      out_re_r    <= rdata_s[2*W-1:W];
      out_im_r    <= rdata_s[W-1:0];
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r2sdf_bitrev_reorder.sv
// Scoreboard bench for r2sdf_bitrev_reorder: the driver queues the natural-order
// frame once it is fully accepted; a negedge monitor pops and compares.
module tb_r2sdf_bitrev_reorder;
  import r2sdf_pkg::*;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int NP = NPTS;

  typedef struct {
    cplx_t        d;
    logic [N-1:0] idx;
    logic         last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r2sdf_bitrev_reorder_if #(.N(N), .W(W)) bus ();
  r2sdf_bitrev_reorder #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t         exp_q[$];
  int           pop_cyc[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           accepted = 0;
  int           stall_cnt = 0;
  int           fr_cnt = 0;
  logic [W-1:0] fr_re[NP];
  logic [W-1:0] fr_im[NP];
  int           br_tab[NP] = '{0, 4, 2, 6, 1, 5, 3, 7};
  bit           mon_en = 1'b0;
  bit           rand_rdy = 1'b0;
  bit           gap_mode = 1'b0;
  logic         rdy_fixed = 1'b1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // natural output j reads the slot written by arrival k = bitrev(j)
  task automatic push_frame();
    exp_t e;
    for (int j = 0; j < NP; j++) begin
      e.d.re = fr_re[br_tab[j]];
      e.d.im = fr_im[br_tab[j]];
      e.idx  = N'(j);
      e.last = (j == NP - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
    int   waitc;
    logic rdy;
    if (gap_mode) begin
      while ($urandom_range(0, 99) < 30) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_im    = im;
    waitc        = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waitc++;
      stall_cnt++;
      if (waitc > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", waitc);
        bus.in_valid = 1'b0;
        return;
      end
    end
    fr_re[fr_cnt] = re;
    fr_im[fr_cnt] = im;
    fr_cnt++;
    accepted++;
    if (fr_cnt == NP) begin
      push_frame();
      fr_cnt = 0;
    end
  endtask

  task automatic send_frame(input logic [W-1:0] base);
    logic [W-1:0] v;
    for (int k = 0; k < NP; k++) begin
      v = base + W'(k);
      send(v, -v);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 600) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // scoreboard monitor plus hold-stability check under backpressure
  initial begin
    exp_t         e;
    logic [W*2+N:0] hold;
    logic [W*2+N:0] cur;
    bit           hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        cur = {bus.out_re, bus.out_im, bus.out_idx, bus.out_last};
        if (bus.out_valid && !bus.out_ready) begin
          if (hold_vld) begin
            n_cmp++;
            if (cur !== hold) begin
              n_err++;
              $display("FAIL hold_stable: got %h, expected %h", cur, hold);
            end
          end
          hold     = cur;
          hold_vld = 1'b1;
        end else begin
          hold_vld = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL spurious_out: got idx=%0d re=%h, expected no output", bus.out_idx, bus.out_re);
          end else begin
            e = exp_q.pop_front();
            pop_cyc.push_back(cyc);
            if (bus.out_re !== e.d.re || bus.out_im !== e.d.im ||
                bus.out_idx !== e.idx || bus.out_last !== e.last) begin
              n_err++;
              $display("FAIL out_sample: got re=%h im=%h idx=%0d last=%0b, expected re=%h im=%h idx=%0d last=%0b",
                       bus.out_re, bus.out_im, bus.out_idx, bus.out_last, e.d.re, e.d.im, e.idx, e.last);
            end
          end
        end
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  initial begin
    int   span;
    logic prev_rdy;
    bus.in_valid = 1'b0;
    bus.in_re    = '0;
    bus.in_im    = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_out_idx", int'(bus.out_idx), 0);
    check("rst_out_re", int'(bus.out_re), 0);
    check("rst_out_im", int'(bus.out_im), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // single frame, re=k im=-k, latency of one edge after last accept
    send_frame(16'h0000);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    check("lat_first_valid", int'(bus.out_valid), 1);
    check("lat_first_idx", int'(bus.out_idx), 0);
    check("lat_first_re", int'(bus.out_re), 0);
    wait_drain();

    // four back-to-back frames at full rate
    stall_cnt = 0;
    pop_cyc.delete();
    for (int f = 0; f < 4; f++) send_frame(W'(8 * f));
    bus.in_valid = 1'b0;
    wait_drain();
    check("b2b_in_ready_stalls", stall_cnt, 0);
    check("b2b_out_count", pop_cyc.size(), 32);
    span = (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size() - 1] - pop_cyc[0] : -1;
    check("b2b_contiguous", span, 31);

    // backpressure: two frames buffered, third blocked until bank 0 drains
    rdy_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    accepted = 0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(16'h1000 + W'(8 * f));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (40) @(negedge clk);
        check("bp_accepted", accepted, 16);
        check("bp_in_ready_low", int'(bus.in_ready), 0);
        rdy_fixed = 1'b1;
        prev_rdy  = bus.in_ready;
        for (int i = 0; i < 100; i++) begin
          prev_rdy = bus.in_ready;
          @(negedge clk);
          if (bus.out_valid && bus.out_last) break;
        end
        check("bp_ready_before_clear", int'(prev_rdy), 0);
        check("bp_ready_after_clear", int'(bus.in_ready), 1);
      end
    join
    wait_drain();
    check("bp_total_accepted", accepted, 24);

    // random output stalls
    rand_rdy = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(16'hC000 + W'(16 * f));
    bus.in_valid = 1'b0;
    wait_drain();
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // random input gaps, data crossing the sign boundary
    gap_mode = 1'b1;
    for (int f = 0; f < 3; f++) send_frame(16'h7FF8 + W'(8 * f));
    gap_mode = 1'b0;
    bus.in_valid = 1'b0;
    wait_drain();

    // reset while frame 0 drains and frame 1 is partially written
    send_frame(16'h3000);
    for (int k = 0; k < 5; k++) send(16'h3008 + W'(k), 16'h0055);
    check("mid_rst_draining", int'(bus.out_valid), 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_out_idx", int'(bus.out_idx), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    exp_q.delete();
    fr_cnt = 0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    send_frame(16'h4000);
    bus.in_valid = 1'b0;
    wait_drain();

    repeat (5) @(posedge clk);
    #1;
    check("final_no_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
